vga_timing_controller: RTL and testbench

//  Generates 640x480@60 Hz VGA raster timing (hsync, vsync, vidOn, pixel x/y) from one system clock.

---
 rtl/vga_timing_controller_if.sv | 24 ++
 rtl/vga_timing_controller.sv | 125 ++++++++++++
 tb/tb_vga_timing_controller.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_controller_if.sv
// VGA raster timing bus: run control in, raster position/sync/strobes out.
interface vga_timing_if #(
  parameter int unsigned CW = 10
);
  logic          enable;
  logic          hsync;
  logic          vsync;
  logic          vidOn;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          pixelTick;
  logic          lineStart;
  logic          frameStart;

  modport master (
    input  enable,
    output hsync, vsync, vidOn, x, y, pixelTick, lineStart, frameStart
  );

  modport slave (
    output enable,
    input  hsync, vsync, vidOn, x, y, pixelTick, lineStart, frameStart
  );
endinterface

// File: rtl/vga_timing_controller.sv
// vga_timing_controller: 640x480@60 VGA raster timing generator.
// Optional build macro VGA_CLK_DIV_EN: internal divide-by-2 so the raster
// runs at clk/2 (50 MHz clk); without it the raster advances every clk.
// All outputs are registered from the next-state counters so position,
// syncs, vidOn and strobes always describe the same pixel.
module vga_timing_controller #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned CW       = 10
) (
  input logic            clk,
  input logic            reset,
  vga_timing_if.master   bus
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SS   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SE   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SS   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SE   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] r_hcnt;
  logic [CW-1:0] r_vcnt;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_vidOn;
  logic          r_pixelTick;
  logic          r_lineStart;
  logic          r_frameStart;

  logic          w_tick;
  logic          w_adv;
  logic [CW-1:0] w_hnext;
  logic [CW-1:0] w_vnext;
  logic          w_hsyn;
  logic          w_vsyn;
  logic          w_vis;

`ifdef VGA_CLK_DIV_EN
  logic r_div;

  // Divide-by-2 pixel enable; first tick on the 2nd clk after reset release.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= 1'b0;
    end else begin
      r_div <= ~r_div;
    end
  end

  // Raster may advance only in the divider's high phase.
  always_comb begin
    w_tick = r_div;
  end
`else
  // Raster may advance on every clk.
  always_comb begin
    w_tick = 1'b1;
  end
`endif

  // Next-state raster counters and their phase decode.
  always_comb begin
    w_adv   = bus.enable & w_tick;
    w_hnext = r_hcnt;
    w_vnext = r_vcnt;
    if (w_adv) begin
      if (r_hcnt == H_LAST) begin
        w_hnext = '0;
        w_vnext = (r_vcnt == V_LAST) ? '0 : r_vcnt + CW'(1);
      end else begin
        w_hnext = r_hcnt + CW'(1);
      end
    end
    w_hsyn = (w_hnext >= H_SS) && (w_hnext < H_SE);
    w_vsyn = (w_vnext >= V_SS) && (w_vnext < V_SE);
    w_vis  = (w_hnext < H_ACT) && (w_vnext < V_ACT);
  end

  // Counter register plus all outputs decoded from the next-state counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hcnt       <= '0;
      r_vcnt       <= '0;
      r_hsync      <= ~SYNC_POL;
      r_vsync      <= ~SYNC_POL;
      r_vidOn      <= 1'b0;
      r_pixelTick  <= 1'b0;
      r_lineStart  <= 1'b0;
      r_frameStart <= 1'b0;
    end else begin
      r_hcnt       <= w_hnext;
      r_vcnt       <= w_vnext;
      r_hsync      <= w_hsyn ? SYNC_POL : ~SYNC_POL;
      r_vsync      <= w_vsyn ? SYNC_POL : ~SYNC_POL;
      r_vidOn      <= w_vis & bus.enable;
      // pixelTick flags the cycle holding a freshly advanced position,
      // aligned with x/y and the strobes.
      r_pixelTick  <= w_adv;
      r_lineStart  <= w_adv & (w_hnext == '0);
      r_frameStart <= w_adv & (w_hnext == '0) & (w_vnext == '0);
    end
  end

  assign bus.x          = r_hcnt;
  assign bus.y          = r_vcnt;
  assign bus.hsync      = r_hsync;
  assign bus.vsync      = r_vsync;
  assign bus.vidOn      = r_vidOn;
  assign bus.pixelTick  = r_pixelTick;
  assign bus.lineStart  = r_lineStart;
  assign bus.frameStart = r_frameStart;
endmodule

// File: tb/tb_vga_timing_controller.sv
// Testbench for vga_timing_controller using a reduced raster geometry so a
// full frame stays short; the reference model tracks the number of advances
// since reset and derives position and phases arithmetically.
`timescale 1ns/1ps
module tb_vga_timing_controller;
  localparam int unsigned CW  = 10;
  localparam int unsigned HA  = 16;
  localparam int unsigned HFP = 4;
  localparam int unsigned HS  = 6;
  localparam int unsigned HBP = 6;
  localparam int unsigned VA  = 12;
  localparam int unsigned VFP = 2;
  localparam int unsigned VS  = 2;
  localparam int unsigned VBP = 3;
  localparam int unsigned HT  = HA + HFP + HS + HBP;
  localparam int unsigned VT  = VA + VFP + VS + VBP;
  localparam int unsigned FRAME = HT * VT;
  localparam bit POL = 1'b0;
`ifdef VGA_CLK_DIV_EN
  localparam bit DIV = 1'b1;
`else
  localparam bit DIV = 1'b0;
`endif
  localparam int unsigned CPT = DIV ? 2 : 1;

  logic clk = 1'b0;
  logic reset = 1'b1;

  vga_timing_if #(.CW(CW)) bus();

  vga_timing_controller #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(POL), .CW(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int unsigned   m_n = 0;
  bit            m_div = 1'b0;
  logic [CW-1:0] e_x, e_y;
  logic          e_vid, e_hs, e_vs, e_tick, e_ls, e_fs;
  logic [CW-1:0] zero = '0;

  function automatic bit in_rng(int unsigned v, int unsigned lo, int unsigned len);
    return (v >= lo) && (v < lo + len);
  endfunction

  // One clk edge: advance the model with the inputs sampled at that edge.
  task automatic step();
    bit adv;
    bit tick;
    @(posedge clk);
    adv = 1'b0;
    if (reset) begin
      m_n   = 0;
      m_div = 1'b0;
    end else begin
      tick  = DIV ? m_div : 1'b1;
      m_div = ~m_div;
      adv   = bus.enable && tick;
      if (adv) m_n = (m_n + 1) % FRAME;
    end
    e_x    = CW'(m_n % HT);
    e_y    = CW'(m_n / HT);
    e_tick = adv;
    e_ls   = adv && (m_n % HT == 0);
    e_fs   = adv && (m_n == 0);
    e_vid  = !reset && bus.enable && (m_n % HT < HA) && (m_n / HT < VA);
    e_hs   = (!reset && in_rng(m_n % HT, HA + HFP, HS)) ? POL : ~POL;
    e_vs   = (!reset && in_rng(m_n / HT, VA + VFP, VS)) ? POL : ~POL;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.enable = 1'b1;
    repeat (5) begin
      step();
      n_cmp++;
      if ({bus.x, bus.y, bus.vidOn, bus.hsync, bus.vsync, bus.pixelTick, bus.lineStart, bus.frameStart}
          !== {zero, zero, 1'b0, ~POL, ~POL, 3'b000}) begin
        n_err++;
        $display("FAIL reset_state: got x=%0d y=%0d vid=%b hs=%b vs=%b tick=%b ls=%b fs=%b, want 0 0 0 %b %b 0 0 0",
                 bus.x, bus.y, bus.vidOn, bus.hsync, bus.vsync, bus.pixelTick, bus.lineStart, bus.frameStart,
                 ~POL, ~POL);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_line();
    int adv_n = 0, hs_lo = 0, vid_n = 0, ls_n = 0, cyc = 0;
    int first_lo = -1, last_lo = -1;
    bit ls_ok = 1'b0;
    bus.enable = 1'b1;
    while (adv_n < HT && cyc < 4 * HT) begin
      step();
      cyc++;
      if (bus.pixelTick) begin
        adv_n++;
        if (bus.hsync === POL) begin
          hs_lo++;
          if (first_lo < 0) first_lo = int'(bus.x);
          last_lo = int'(bus.x);
        end
        if (bus.vidOn) vid_n++;
        if (bus.lineStart) begin
          ls_n++;
          ls_ok = (bus.x == 0);
        end
      end
    end
    n_cmp++;
    if (adv_n != HT) begin n_err++; $display("FAIL line_timeout: advances=%0d want %0d", adv_n, HT); end
    n_cmp++;
    if (hs_lo != HS) begin n_err++; $display("FAIL hsync_width: got %0d want %0d", hs_lo, HS); end
    n_cmp++;
    if (first_lo != int'(HA + HFP)) begin n_err++; $display("FAIL hsync_first: got %0d want %0d", first_lo, HA + HFP); end
    n_cmp++;
    if (last_lo != int'(HA + HFP + HS - 1)) begin n_err++; $display("FAIL hsync_last: got %0d want %0d", last_lo, HA + HFP + HS - 1); end
    n_cmp++;
    if (vid_n != HA) begin n_err++; $display("FAIL line_vidOn: got %0d want %0d", vid_n, HA); end
    n_cmp++;
    if (ls_n != 1 || !ls_ok) begin n_err++; $display("FAIL lineStart: got count=%0d at_x0=%b want 1 1", ls_n, ls_ok); end
  endtask

  task automatic test_frame();
    int cyc = 0, adv_n = 0, vs_lo = 0, vid_lines = 0;
    bit seen = 1'b0;
    bus.enable = 1'b1;
    while (!seen && cyc < 3 * FRAME * CPT) begin
      step();
      cyc++;
      seen = bus.frameStart;
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL frame_wait: no frameStart within %0d clk", cyc); end
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 3 * FRAME * CPT) begin
      step();
      cyc++;
      if (bus.pixelTick) begin
        adv_n++;
        if (bus.vsync === POL) vs_lo++;
        if (bus.x == 0 && bus.vidOn) vid_lines++;
        seen = bus.frameStart;
      end
    end
    n_cmp++;
    if (adv_n != FRAME) begin n_err++; $display("FAIL frame_period: got %0d ticks want %0d", adv_n, FRAME); end
    n_cmp++;
    if (vs_lo != VS * HT) begin n_err++; $display("FAIL vsync_width: got %0d ticks want %0d", vs_lo, VS * HT); end
    n_cmp++;
    if (vid_lines != VA) begin n_err++; $display("FAIL active_lines: got %0d want %0d", vid_lines, VA); end
  endtask

  task automatic test_wrap();
    int cyc = 0;
    bit at_end = 1'b0;
    bit got = 1'b0;
    bus.enable = 1'b1;
    while (!at_end && cyc < 3 * FRAME * CPT) begin
      step();
      cyc++;
      at_end = (bus.x == CW'(HT - 1)) && (bus.y == CW'(VT - 1));
    end
    cyc = 0;
    while (at_end && !got && cyc < 4) begin
      step();
      cyc++;
      got = bus.pixelTick;
    end
    n_cmp++;
    if ({bus.x, bus.y, bus.frameStart, bus.lineStart, got} !== {zero, zero, 3'b111}) begin
      n_err++;
      $display("FAIL wrap: got x=%0d y=%0d fs=%b ls=%b adv=%b want 0 0 1 1 1",
               bus.x, bus.y, bus.frameStart, bus.lineStart, got);
    end
  endtask

  task automatic test_enable();
    int cyc = 0;
    bit hit = 1'b0;
    bit got = 1'b0;
    logic hs0, vs0;
    bus.enable = 1'b1;
    while (!hit && cyc < 3 * FRAME * CPT) begin
      step();
      cyc++;
      hit = bus.pixelTick && bus.x == 10 && bus.y == 5;
    end
    n_cmp++;
    if (!hit) begin n_err++; $display("FAIL enable_wait: position (10,5) not reached"); end
    hs0 = bus.hsync;
    vs0 = bus.vsync;
    bus.enable = 1'b0;
    repeat (10) begin
      step();
      n_cmp++;
      if ({bus.x, bus.y, bus.vidOn, bus.hsync, bus.vsync} !== {CW'(10), CW'(5), 1'b0, hs0, vs0}) begin
        n_err++;
        $display("FAIL enable_hold: got x=%0d y=%0d vid=%b hs=%b vs=%b want 10 5 0 %b %b",
                 bus.x, bus.y, bus.vidOn, bus.hsync, bus.vsync, hs0, vs0);
      end
    end
    bus.enable = 1'b1;
    cyc = 0;
    while (!got && cyc < 4) begin
      step();
      cyc++;
      got = bus.pixelTick;
    end
    n_cmp++;
    if ({bus.x, bus.y, got} !== {CW'(11), CW'(5), 1'b1}) begin
      n_err++;
      $display("FAIL enable_resume: got x=%0d y=%0d adv=%b want 11 5 1", bus.x, bus.y, got);
    end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    bit hit = 1'b0;
    bit fs = 1'b0;
    bus.enable = 1'b1;
    while (!hit && cyc < 3 * FRAME * CPT) begin
      step();
      cyc++;
      hit = bus.x == 22 && bus.y == 9;
    end
    reset = 1'b1;
    step();
    n_cmp++;
    if ({bus.x, bus.y, bus.hsync, bus.vsync, bus.vidOn, bus.pixelTick} !== {zero, zero, ~POL, ~POL, 2'b00}) begin
      n_err++;
      $display("FAIL reset_mid: got x=%0d y=%0d hs=%b vs=%b vid=%b tick=%b want 0 0 %b %b 0 0",
               bus.x, bus.y, bus.hsync, bus.vsync, bus.vidOn, bus.pixelTick, ~POL, ~POL);
    end
    reset = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 4; k++) begin
      step();
      cyc++;
      n_cmp++;
      if (bus.pixelTick !== (DIV ? ((k % 2) == 0) : 1'b1)) begin
        n_err++;
        $display("FAIL tick_pattern: clk %0d got %b want %b", k, bus.pixelTick, DIV ? ((k % 2) == 0) : 1'b1);
      end
    end
    while (!fs && cyc < 3 * FRAME * CPT) begin
      step();
      cyc++;
      fs = bus.frameStart;
    end
    n_cmp++;
    if (cyc != int'(FRAME * CPT)) begin
      n_err++;
      $display("FAIL frame_clk: first frameStart after %0d clk want %0d", cyc, FRAME * CPT);
    end
  endtask

  task automatic test_random();
    logic [2*CW+5:0] act, exp_v;
    for (int i = 0; i < 4000; i++) begin
      reset      = ($urandom_range(0, 1499) == 0);
      bus.enable = ($urandom_range(0, 9) != 0);
      step();
      act   = {bus.x, bus.y, bus.vidOn, bus.hsync, bus.vsync, bus.pixelTick, bus.lineStart, bus.frameStart};
      exp_v = {e_x, e_y, e_vid, e_hs, e_vs, e_tick, e_ls, e_fs};
      n_cmp++;
      if (act !== exp_v) begin
        n_err++;
        $display("FAIL random[%0d]: got {x,y,vid,hs,vs,tick,ls,fs}=%h want %h", i, act, exp_v);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    bus.enable = 1'b0;
    test_reset();
    test_line();
    test_frame();
    test_wrap();
    test_enable();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
